// File: rtl/cpu_sm_xfer.sv
// cpu_sm_xfer: DMA bus-master transfer sequencer.
// Moves longwords between a FIFO and a 68k-style asynchronous bus:
// request/grant/acknowledge arbitration, AS_/DS_ strobes, and 32- or 16-bit
// dynamic bus sizing via DSACK_. Every output is taken directly from a flop.
// Optional feature: define CPU_SM_BUS_TIMEOUT_EN to compile in an 8-bit
// WAIT watchdog that raises a sticky BUS_ERR and releases the bus.
module cpu_sm_xfer #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned BCNT_W    = 4
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       DMAENA,
  input  logic       DMADIR,
  input  logic       FIFOEMPTY,
  input  logic       FIFOFULL,
  input  logic       FLUSHFIFO,
  input  logic       BGRANT_,
  input  logic [1:0] DSACK_,
  output logic       BR_,
  output logic       BGACK_,
  output logic       AS_,
  output logic       DS_,
  output logic       RW,
  output logic       A1,
  output logic       FIFO_RD,
  output logic       FIFO_WR,
  output logic       ADDR_INC,
  output logic       BUSY,
  output logic       BUS_ERR
);

  // S_CHK is the decision cycle after ACK, so the FIFO flag reflects the pop/push.
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_OWN, S_STRB, S_WAIT, S_ACK, S_CHK, S_REL
  } state_e;

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   beat_q, beat_d;
  logic                a1_q, a1_d;
  logic                br_q, br_d;
  logic                bgack_q, bgack_d;
  logic                as_q, as_d;
  logic                ds_q, ds_d;
  logic                rw_q, rw_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                inc_q, inc_d;
  logic                busy_q, busy_d;
  logic                start_req;
  logic                ack32;
  logic                ack16;
  logic                burst_end;
  logic                timeout;

  assign start_req = DMAENA & ((DMADIR & (FIFOFULL | (FLUSHFIFO & ~FIFOEMPTY)))
                               | (~DMADIR & FIFOEMPTY));
  // 2'b10 (8-bit port) and 2'b11 both count as no acknowledge.
  assign ack32     = (DSACK_ == 2'b00);
  assign ack16     = (DSACK_ == 2'b01);
  assign burst_end = (beat_q == BCNT_W'(BURST_LEN)) | (DMADIR & FIFOEMPTY)
                   | (~DMADIR & FIFOFULL) | ~DMAENA;

`ifdef CPU_SM_BUS_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;

  // Watchdog: counts consecutive WAIT cycles; the 256th unacknowledged one times out.
  assign timeout = (state_q == S_WAIT) & ~(ack32 | ack16) & (wd_q == 8'hFF);

  // Watchdog counter and sticky error next-state.
  always_comb begin
    wd_d  = '0;
    err_d = err_q;
    if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
      wd_d = wd_q + 8'd1;
    end
    if (timeout) begin
      err_d = 1'b1;
    end else if (!DMAENA) begin
      err_d = 1'b0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign BUS_ERR = err_q;
`else
  assign timeout = 1'b0;
  assign BUS_ERR = 1'b0;
`endif

  // State, beat counter and word-select registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      a1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a1_q    <= a1_d;
    end
  end

  // Next-state logic; a started longword always runs to its acknowledge.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    a1_d    = a1_q;
    unique case (state_q)
      S_IDLE: if (start_req) state_d = S_REQ;
      S_REQ: begin
        if (!DMAENA)       state_d = S_IDLE;
        else if (!BGRANT_) state_d = S_OWN;
      end
      S_OWN: begin
        beat_d  = '0;
        a1_d    = 1'b0;
        state_d = DMAENA ? S_STRB : S_REL;
      end
      S_STRB: state_d = S_WAIT;
      S_WAIT: begin
        if (timeout) begin
          a1_d    = 1'b0;
          state_d = S_REL;
        end else if (ack32 || (ack16 && a1_q)) begin
          a1_d    = 1'b0;
          state_d = S_ACK;
        end else if (ack16) begin
          a1_d    = 1'b1;
          state_d = S_STRB;
        end
      end
      S_ACK: begin
        beat_d  = beat_q + BCNT_W'(1);
        state_d = S_CHK;
      end
      S_CHK: state_d = burst_end ? S_REL : S_STRB;
      S_REL: begin
        beat_d  = '0;
        a1_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so each registered output lines up with its state.
  always_comb begin
    br_d    = 1'b1;
    bgack_d = 1'b1;
    as_d    = 1'b1;
    ds_d    = 1'b1;
    rw_d    = 1'b1;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    inc_d   = 1'b0;
    busy_d  = (state_d != S_IDLE);
    unique case (state_d)
      S_REQ: br_d = 1'b0;
      S_OWN, S_CHK: bgack_d = 1'b0;
      S_STRB: begin
        bgack_d = 1'b0;
        as_d    = 1'b0;
        rw_d    = ~DMADIR;
      end
      S_WAIT: begin
        bgack_d = 1'b0;
        as_d    = 1'b0;
        ds_d    = 1'b0;
        rw_d    = ~DMADIR;
      end
      S_ACK: begin
        bgack_d = 1'b0;
        rd_d    = DMADIR;
        wr_d    = ~DMADIR;
        inc_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      br_q    <= 1'b1;
      bgack_q <= 1'b1;
      as_q    <= 1'b1;
      ds_q    <= 1'b1;
      rw_q    <= 1'b1;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      inc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      br_q    <= br_d;
      bgack_q <= bgack_d;
      as_q    <= as_d;
      ds_q    <= ds_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      inc_q   <= inc_d;
      busy_q  <= busy_d;
    end
  end

  assign BR_      = br_q;
  assign BGACK_   = bgack_q;
  assign AS_      = as_q;
  assign DS_      = ds_q;
  assign RW       = rw_q;
  assign A1       = a1_q;
  assign FIFO_RD  = rd_q;
  assign FIFO_WR  = wr_q;
  assign ADDR_INC = inc_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_cpu_sm_xfer.sv
// tb_cpu_sm_xfer: cycle table for a 4-beat 32-bit write burst and REQ abort,
// plus burst sequences for 16-bit reads, FIFO flush, DMAENA drop mid-WAIT,
// asynchronous reset during WAIT and (with CPU_SM_BUS_TIMEOUT_EN) the watchdog.
module tb_cpu_sm_xfer;

  localparam int DEPTH = 16;

  // Output vector order: {BR_,BGACK_,AS_,DS_,RW,A1,FIFO_RD,FIFO_WR,ADDR_INC,BUSY}
  localparam logic [9:0] O_IDLE  = 10'b1111100000;
  localparam logic [9:0] O_REQ   = 10'b0111100001;
  localparam logic [9:0] O_OWN   = 10'b1011100001;
  localparam logic [9:0] O_STRBW = 10'b1001000001;
  localparam logic [9:0] O_WAITW = 10'b1000000001;
  localparam logic [9:0] O_ACKRD = 10'b1011101011;
  localparam logic [9:0] O_CHK   = 10'b1011100001;
  localparam logic [9:0] O_REL   = 10'b1111100001;

  typedef struct {
    logic [7:0] in;   // {DMAENA,DMADIR,FIFOEMPTY,FIFOFULL,FLUSHFIFO,BGRANT_,DSACK_}
    logic [9:0] exp;
  } vec_t;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       DMAENA, DMADIR, FIFOEMPTY, FIFOFULL, FLUSHFIFO, BGRANT_;
  logic [1:0] DSACK_;
  logic       BR_, BGACK_, AS_, DS_, RW, A1, FIFO_RD, FIFO_WR, ADDR_INC, BUSY, BUS_ERR;
  logic [9:0] obs;

  int         n_vec = 0;
  int         n_bad = 0;
  int         level;
  int         n_strb, n_wait, n_rd, n_wr, n_inc, n_rel, n_idle_busy;
  logic [15:0] a1_pat;
  logic       err_at_rel;
  logic       burst_done;
  vec_t       tbl[$];

  cpu_sm_xfer #(.BURST_LEN(4), .BCNT_W(4)) dut (
    .CLK(CLK), .nRESET(nRESET), .DMAENA(DMAENA), .DMADIR(DMADIR),
    .FIFOEMPTY(FIFOEMPTY), .FIFOFULL(FIFOFULL), .FLUSHFIFO(FLUSHFIFO),
    .BGRANT_(BGRANT_), .DSACK_(DSACK_), .BR_(BR_), .BGACK_(BGACK_),
    .AS_(AS_), .DS_(DS_), .RW(RW), .A1(A1), .FIFO_RD(FIFO_RD),
    .FIFO_WR(FIFO_WR), .ADDR_INC(ADDR_INC), .BUSY(BUSY), .BUS_ERR(BUS_ERR)
  );

  assign obs = {BR_, BGACK_, AS_, DS_, RW, A1, FIFO_RD, FIFO_WR, ADDR_INC, BUSY};

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one bus tenure against a FIFO-level model and a BGRANT_ that follows BR_ by a cycle.
  // The first `hold` WAIT cycles see hold_val on DSACK_, later ones see mode.
  task automatic run_burst(input string nm, input logic dir, input int lvl, input logic flush,
                           input logic [1:0] mode, input int hold, input logic [1:0] hold_val,
                           input logic drop_at_wait);
    bit seen_busy;
    int cyc;
    level = lvl; DMADIR = dir; FLUSHFIFO = flush; DSACK_ = mode; BGRANT_ = 1'b1;
    FIFOEMPTY = (level == 0); FIFOFULL = (level >= DEPTH);
    n_strb = 0; n_wait = 0; n_rd = 0; n_wr = 0; n_inc = 0; n_rel = 0;
    a1_pat = '0; err_at_rel = 1'b0; seen_busy = 0; burst_done = 1'b0; cyc = 0;
    @(negedge CLK);
    DMAENA = 1'b1;
    while (!burst_done && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      if (BUSY) seen_busy = 1;
      if (!AS_ && DS_) begin
        n_strb++;
        a1_pat = {a1_pat[14:0], A1};
      end
      if (!AS_ && !DS_) begin
        n_wait++;
        if (drop_at_wait) DMAENA = 1'b0;
      end
      if (FIFO_RD) begin level--; n_rd++; end
      if (FIFO_WR) begin level++; n_wr++; end
      if (ADDR_INC) n_inc++;
      if (BUSY && BR_ && BGACK_) begin
        n_rel++;
        err_at_rel = BUS_ERR;
        DMAENA = 1'b0;
      end
      if (seen_busy && !BUSY) burst_done = 1'b1;
      BGRANT_   = BR_;
      DSACK_    = (n_wait >= 1 && n_wait <= hold) ? hold_val : mode;
      FIFOEMPTY = (level == 0);
      FIFOFULL  = (level >= DEPTH);
    end
    chk({nm, "_finished"}, {31'd0, burst_done}, 32'd1);
    n_idle_busy = 0;
    repeat (3) begin
      @(negedge CLK);
      if (BUSY) n_idle_busy++;
    end
    chk({nm, "_stays_idle"}, n_idle_busy, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit found;
    nRESET = 1'b0; DMAENA = 1'b0; DMADIR = 1'b0; FIFOEMPTY = 1'b0; FIFOFULL = 1'b0;
    FLUSHFIFO = 1'b0; BGRANT_ = 1'b1; DSACK_ = 2'b11;

    // Cycle table: 4-beat 32-bit write, grant after 2 cycles, then REQ aborted by DMAENA.
    tbl.push_back('{8'b11010100, O_REQ});
    tbl.push_back('{8'b11000100, O_REQ});
    tbl.push_back('{8'b11000000, O_OWN});
    for (int b = 0; b < 4; b++) begin
      tbl.push_back('{8'b11000000, O_STRBW});
      tbl.push_back('{8'b11000000, O_WAITW});
      tbl.push_back('{8'b11000000, O_ACKRD});
      tbl.push_back('{8'b11000000, O_CHK});
    end
    tbl.push_back('{8'b11000000, O_REL});
    tbl.push_back('{8'b11000000, O_IDLE});
    tbl.push_back('{8'b11000000, O_IDLE});
    tbl.push_back('{8'b11010100, O_REQ});
    tbl.push_back('{8'b01010100, O_IDLE});
    tbl.push_back('{8'b01010100, O_IDLE});

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", {22'd0, obs}, {22'd0, O_IDLE});
    chk("reset_bus_err", {31'd0, BUS_ERR}, 32'd0);
    @(negedge CLK);
    nRESET = 1'b1;

    foreach (tbl[i]) begin
      @(negedge CLK);
      {DMAENA, DMADIR, FIFOEMPTY, FIFOFULL, FLUSHFIFO, BGRANT_, DSACK_} = tbl[i].in;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d", i), {22'd0, obs}, {22'd0, tbl[i].exp});
    end

    // 16-bit read: two strobes per longword, A1 0 then 1.
    run_burst("rd16", 1'b0, 0, 1'b0, 2'b01, 0, 2'b11, 1'b0);
    chk("rd16_strobes", n_strb, 32'd8);
    chk("rd16_a1_seq", {16'd0, a1_pat}, 32'h0055);
    chk("rd16_fifo_wr", n_wr, 32'd4);
    chk("rd16_fifo_rd", n_rd, 32'd0);
    chk("rd16_addr_inc", n_inc, 32'd4);
    chk("rd16_bus_err", {31'd0, err_at_rel}, 32'd0);

    // Flush of 2 held words: stops when the FIFO empties.
    run_burst("flush", 1'b1, 2, 1'b1, 2'b00, 0, 2'b11, 1'b0);
    chk("flush_strobes", n_strb, 32'd2);
    chk("flush_fifo_rd", n_rd, 32'd2);
    chk("flush_addr_inc", n_inc, 32'd2);
    chk("flush_level", level, 32'd0);
    chk("flush_rel", n_rel, 32'd1);

    // DMAENA dropped in WAIT with 3 cycles of 8-bit (ignored) DSACK_: longword still completes.
    run_burst("abort", 1'b1, DEPTH, 1'b0, 2'b00, 3, 2'b10, 1'b1);
    chk("abort_waits", n_wait, 32'd4);
    chk("abort_strobes", n_strb, 32'd1);
    chk("abort_fifo_rd", n_rd, 32'd1);
    chk("abort_addr_inc", n_inc, 32'd1);
    chk("abort_rel", n_rel, 32'd1);

    // Asynchronous reset in the middle of WAIT.
    level = DEPTH; DMADIR = 1'b1; FLUSHFIFO = 1'b0; FIFOFULL = 1'b1; FIFOEMPTY = 1'b0;
    DSACK_ = 2'b11; DMAENA = 1'b1;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge CLK);
      BGRANT_ = BR_;
      if (!AS_ && !DS_) found = 1;
    end
    chk("rst_reach_wait", {31'd0, found}, 32'd1);
    #2 nRESET = 1'b0;
    #1;
    chk("rst_async_outputs", {21'd0, obs, BUS_ERR}, {21'd0, O_IDLE, 1'b0});
    DMAENA = 1'b0;
    @(negedge CLK);
    nRESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_no_strobes_after", {22'd0, obs}, {22'd0, O_IDLE});

`ifdef CPU_SM_BUS_TIMEOUT_EN
    // No acknowledge at all: watchdog fires on the 256th WAIT cycle.
    run_burst("tmo", 1'b1, DEPTH, 1'b0, 2'b11, 0, 2'b11, 1'b0);
    chk("tmo_waits", n_wait, 32'd256);
    chk("tmo_bus_err", {31'd0, err_at_rel}, 32'd1);
    chk("tmo_fifo_rd", n_rd, 32'd0);
    chk("tmo_fifo_wr", n_wr, 32'd0);
    chk("tmo_addr_inc", n_inc, 32'd0);
    chk("tmo_released", {22'd0, obs}, {22'd0, O_IDLE});
    chk("tmo_err_cleared", {31'd0, BUS_ERR}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sm_xfer.md
CPU_SM_XFER -- requirements
Module: cpu_sm_xfer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning the maximum number of longwords moved per bus tenure (legal range 1..15).
REQ-002 SHALL have parameter BCNT_W, default 4, meaning the beat counter width; BURST_LEN < 2**BCNT_W.
REQ-003 Ports, one per line:
- CLK  in  1  single clock; all state changes on the rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- DMAENA  in  1  DMA enabled.
- DMADIR  in  1  1 = FIFO-to-bus (memory write); 0 = bus-to-FIFO.
- FIFOEMPTY, FIFOFULL  in  1  FIFO status.
- FLUSHFIFO  in  1  drain a partial FIFO to the bus.
- BGRANT_  in  1  bus grant, active low.
- DSACK_  in  2  [1]=DSACK1_, [0]=DSACK0_, active low.
- BR_  out  1  bus request, active low.
- BGACK_  out  1  bus grant acknowledge, active low.
- AS_, DS_  out  1  address/data strobes, active low.
- RW  out  1  1 = read cycle.
- A1  out  1  word select within a longword.
- FIFO_RD  out  1  one-cycle pop strobe.
- FIFO_WR  out  1  one-cycle push strobe.
- ADDR_INC  out  1  one-cycle pulse: advance the address by 4.
- BUSY  out  1  high in any state other than IDLE.
- BUS_ERR  out  1  sticky timeout flag.

Function
REQ-004 SHALL implement the states IDLE, REQ, OWN, STRB, WAIT, ACK and REL.
REQ-005 IDLE->REQ SHALL occur when DMAENA & ((DMADIR & (FIFOFULL | (FLUSHFIFO & ~FIFOEMPTY))) | (~DMADIR & FIFOEMPTY)).
REQ-006 REQ SHALL drive BR_=0 and move to OWN on the first edge that samples BGRANT_=0.
REQ-007 OWN SHALL drive BGACK_=0, drive BR_=1, clear the beat counter and A1, and move to STRB the next cycle.
REQ-008 STRB SHALL drive AS_=0 with RW=~DMADIR, then move to WAIT; WAIT SHALL drive AS_=0 and DS_=0.
REQ-009 In WAIT, DSACK_=2'b00 (32-bit port) SHALL complete a longword and move to ACK with ADDR_INC=1.
REQ-010 In WAIT, DSACK_=2'b01 (16-bit port) with A1=0 SHALL set A1=1 and return to STRB.
REQ-011 In WAIT, DSACK_=2'b01 with A1=1 SHALL complete the longword: clear A1, assert ADDR_INC, move to ACK.
REQ-012 In WAIT, DSACK_=2'b10 (8-bit port) SHALL be treated as no acknowledge.
REQ-013 ACK SHALL negate AS_ and DS_, pulse FIFO_RD (DMADIR=1) or FIFO_WR (DMADIR=0), and increment the beat counter.
REQ-014 ACK->REL SHALL be taken if, after the increment, beats==BURST_LEN, or DMADIR & FIFOEMPTY-after-pop, or ~DMADIR & FIFOFULL-after-push, or ~DMAENA; otherwise ACK->STRB.
REQ-015 "FIFOEMPTY-after-pop" / "FIFOFULL-after-push" SHALL be the FIFO flag sampled in the cycle after ACK; one REL-decision cycle SHALL be inserted for this purpose.
REQ-016 REL SHALL negate BGACK_ and return to IDLE.
REQ-017 ~DMAENA SHALL abort from REQ to IDLE; from STRB/WAIT the current longword SHALL complete first (never a partial bus cycle).
REQ-018 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-019 nRESET=0 SHALL asynchronously force IDLE, BR_=BGACK_=AS_=DS_=1, RW=1, A1=0, FIFO_RD=FIFO_WR=ADDR_INC=0, BUSY=0, BUS_ERR=0, and beat counter=0.
REQ-020 Reset asserted mid-cycle SHALL release the bus immediately; no strobes are generated after reset deassertion until a new IDLE->REQ condition occurs.

Configuration
REQ-021 Macro CPU_SM_BUS_TIMEOUT_EN SHALL compile in an 8-bit WAIT watchdog.
- Defined: 256 consecutive WAIT cycles without a valid DSACK_ set BUS_ERR, move to REL, and generate no FIFO strobe; BUS_ERR is cleared only by reset or by DMAENA=0.
- Undefined: WAIT persists indefinitely and BUS_ERR is tied 0.

Verification
REQ-022 DMADIR=1, FIFOFULL=1, BURST_LEN=4, BGRANT_=0 after 2 cycles, DSACK_=00 -> 4 AS_ cycles, 4 FIFO_RD pulses, 4 ADDR_INC pulses, then BGACK_ released.
REQ-023 DMADIR=0, FIFOEMPTY=1, DSACK_=01 -> each longword takes 2 strobes (A1 0 then 1), with 1 FIFO_WR and 1 ADDR_INC per longword.
REQ-024 FLUSHFIFO=1 with 2 words held, FIFOEMPTY rising after the 2nd pop -> exactly 2 transfers, then REL and IDLE.
REQ-025 DMAENA dropped during WAIT -> the longword completes on DSACK, then REL; no further STRB.
REQ-026 nRESET pulsed during WAIT -> all outputs take their reset values in the same cycle, asynchronously.
REQ-027 With the macro defined, DSACK_ held at 11 for 256 cycles -> BUS_ERR=1, bus released, FIFO strobes 0.
